motor_dir_sequencer: RTL and testbench
======================================

Name: motor_dir_sequencer

Overview:
- Sequences one H-bridge motor channel.
- Accepts direction/duty commands over a valid/ready handshake and drives bridge inputs in1/in2 plus PWM enable en.
- Inserts a programmable dead time whenever the bridge input pattern changes, so both legs are never switched in the same cycle.
- Sits between the command decoder and the 3-bit bridge-pin mapping of the single-motor path.

Parameters:
- PWM_BITS, 8: width of duty command and PWM counter; period = 2^PWM_BITS clk cycles.
- DEAD_CYCLES, 50: clk cycles with in1=in2=en=0 inserted on a pattern change; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_dir  input  2  00 coast, 01 forward, 10 reverse, 11 brake.
- cmd_duty  input  PWM_BITS  requested duty; ignored for coast/brake.
- in1  output  1  bridge input 1.
- in2  output  1  bridge input 2.
- en  output  1  bridge enable / PWM.
- busy  output  1  high while in DEAD state.
- cur_dir  output  2  direction currently applied to bridge (encoding as cmd_dir).

Behaviour:
- Reset (rst=1 at edge): state COAST; in1=in2=en=0; cur_dir=00; busy=0; cmd_ready=1; duty and pending duty=0; PWM counter=0; dead counter=0. Reset overrides everything, including mid-DEAD.
- Handshake: command accepted on a clk edge with cmd_valid=1 and cmd_ready=1. cmd_ready = (state != DEAD). Commands presented during DEAD are held off, not dropped.
- PWM counter: free-running 0..2^PWM_BITS-1, wraps to 0. pwm = (cnt < duty).
  - duty=0 gives constant low.
  - duty=2^PWM_BITS-1 is high for all but one cycle per period.
- Duty update: an accepted cmd_duty goes to pending. Duty loads from pending only on the cycle cnt == 2^PWM_BITS-1, so it takes effect from cnt=0. There is no mid-period glitch.
- States:
  - COAST: in1=0, in2=0, en=0.
  - FWD: in1=1, in2=0, en=pwm.
  - REV: in1=0, in2=1, en=pwm.
  - BRAKE: in1=1, in2=1, en=1.
  - DEAD: in1=in2=en=0, busy=1, target dir held in register.
- Transitions on accept:
  - Same dir as cur_dir: state unchanged, duty pending update only.
  - cmd_dir=coast: go to COAST next cycle, no dead time; cur_dir=00.
  - Any other dir change: go to DEAD; dead counter loads DEAD_CYCLES-1.
- DEAD: counter decrements each cycle. At 0, enter the target state next cycle and set cur_dir to the target. Total outputs-low time is exactly DEAD_CYCLES cycles.
- Entry into FWD/REV from DEAD also loads pending duty into duty immediately, and the PWM counter resets to 0.
- All outputs are registered; latency from accept to output change is 1 cycle.
- Invalid states recover to COAST.

Optional Feature:
- Macro: SOFT_START_EN.
- Defined: at each PWM wrap in FWD/REV, duty steps by 1 toward pending, up or down. It does not jump.
  - Entry into FWD/REV from DEAD starts with duty=0 and ramps.
  - Same-dir update ramps from the current duty.
  - COAST/BRAKE force duty=0.
- Not defined: duty loads pending directly, as described above. No ramp logic is synthesised.

Test Plan (PWM_BITS=4, DEAD_CYCLES=3 unless noted):
- Reset, then idle 20 cycles -> in1=in2=en=0, cur_dir=00, cmd_ready=1, busy=0 throughout.
- From COAST, accept dir=01, duty=8 -> exactly 3 cycles with in1=in2=en=0 and busy=1, then in1=1, in2=0, en high for cnt 0..7 and low for 8..15, repeating every 16 cycles.
- In FWD duty=8, accept dir=01, duty=4 at cnt=5 -> current period completes with duty 8; from next cnt=0, en is high for 4 cycles. No DEAD is entered.
- In FWD, accept dir=10 -> 3 dead cycles (in1=in2=0), then in2=1, in1=0. Verify no cycle has in1=in2=1. cmd_valid held during DEAD sees cmd_ready=0 and is accepted on the first REV cycle.
- In REV, accept dir=11 -> DEAD 3 cycles then in1=in2=en=1. Then accept dir=00 -> next cycle in1=in2=en=0, no dead time. Assert rst during a DEAD run -> next cycle COAST, busy=0.
- SOFT_START_EN defined, COAST to FWD duty=3 -> after DEAD, per-period duty sequence 0, 1, 2, 3, 3.

Source files
------------

// File: rtl/motor_dir_sequencer.sv
// +--------------------------------------------------------------------------+
// | motor_dir_sequencer : H-bridge direction/PWM sequencer with dead time     |
// | Optional SOFT_START_EN: duty ramps 1 LSB per PWM period toward target.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module motor_dir_sequencer #(
   parameter int PWM_BITS    = 8,
   parameter int DEAD_CYCLES = 50
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_dir,
   input  logic [PWM_BITS-1:0] cmd_duty,
   output logic                in1,
   output logic                in2,
   output logic                en,
   output logic                busy,
   output logic [1:0]          cur_dir
);

   localparam logic [1:0]          c_dir_coast = 2'b00;
   localparam logic [1:0]          c_dir_fwd   = 2'b01;
   localparam logic [1:0]          c_dir_rev   = 2'b10;
   localparam logic [1:0]          c_dir_brake = 2'b11;
   localparam logic [PWM_BITS-1:0] c_cnt_max   = '1;
   localparam logic [15:0]         c_dead_load = 16'(DEAD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_COAST = 3'd0,
      ST_FWD   = 3'd1,
      ST_REV   = 3'd2,
      ST_BRAKE = 3'd3,
      ST_DEAD  = 3'd4
   } state_t;

   state_t              r_state, w_state_next;
   logic [1:0]          r_target, w_target_next;
   logic [1:0]          r_cur_dir, w_cur_dir_next;
   logic [15:0]         r_dead_cnt, w_dead_next;
   logic [PWM_BITS-1:0] r_cnt, w_cnt_next;
   logic [PWM_BITS-1:0] r_duty, w_duty_next;
   logic [PWM_BITS-1:0] r_pending, w_pending_next;
   logic                r_in1, r_in2, r_en, r_busy, r_ready;
   logic                w_in1_next, w_in2_next, w_en_next, w_busy_next, w_ready_next;
   logic                w_pwm;
   logic                w_accept;
   logic                w_wrap;

   assign w_accept = cmd_valid && r_ready;
   assign w_wrap   = (r_cnt == c_cnt_max);

   always_comb begin
      w_state_next   = r_state;
      w_target_next  = r_target;
      w_cur_dir_next = r_cur_dir;
      w_dead_next    = r_dead_cnt;
      w_pending_next = r_pending;
      w_cnt_next     = r_cnt + 1'b1;
      w_duty_next    = r_duty;

      // Duty only changes at the period boundary so the running period never glitches.
`ifdef SOFT_START_EN
      if (w_wrap && (r_state == ST_FWD || r_state == ST_REV)) begin
         if (r_duty < r_pending) begin
            w_duty_next = r_duty + 1'b1;
         end else if (r_duty > r_pending) begin
            w_duty_next = r_duty - 1'b1;
         end
      end
`else
      if (w_wrap) begin
         w_duty_next = r_pending;
      end
`endif

      case (r_state)
         ST_COAST, ST_FWD, ST_REV, ST_BRAKE: begin
            if (w_accept) begin
               if (cmd_dir == c_dir_fwd || cmd_dir == c_dir_rev) begin
                  w_pending_next = cmd_duty;
               end
               if (cmd_dir != r_cur_dir) begin
                  if (cmd_dir == c_dir_coast) begin
                     w_state_next   = ST_COAST;
                     w_cur_dir_next = c_dir_coast;
                  end else begin
                     w_state_next  = ST_DEAD;
                     w_target_next = cmd_dir;
                     w_dead_next   = c_dead_load;
                  end
               end
            end
         end
         ST_DEAD: begin
            if (r_dead_cnt == '0) begin
               w_cur_dir_next = r_target;
               case (r_target)
                  c_dir_fwd:   w_state_next = ST_FWD;
                  c_dir_rev:   w_state_next = ST_REV;
                  c_dir_brake: w_state_next = ST_BRAKE;
                  default:     w_state_next = ST_COAST;
               endcase
               // Driving entry restarts the PWM period so the first pulse is full length.
               if (r_target == c_dir_fwd || r_target == c_dir_rev) begin
                  w_cnt_next = '0;
`ifdef SOFT_START_EN
                  w_duty_next = '0;
`else
                  w_duty_next = r_pending;
`endif
               end
            end else begin
               w_dead_next = r_dead_cnt - 1'b1;
            end
         end
         default: begin
            w_state_next   = ST_COAST;
            w_cur_dir_next = c_dir_coast;
         end
      endcase

`ifdef SOFT_START_EN
      if (w_state_next == ST_COAST || w_state_next == ST_BRAKE) begin
         w_duty_next = '0;
      end
`endif

      w_pwm        = (w_cnt_next < w_duty_next);
      w_in1_next   = 1'b0;
      w_in2_next   = 1'b0;
      w_en_next    = 1'b0;
      w_busy_next  = 1'b0;
      w_ready_next = 1'b1;
      case (w_state_next)
         ST_FWD: begin
            w_in1_next = 1'b1;
            w_en_next  = w_pwm;
         end
         ST_REV: begin
            w_in2_next = 1'b1;
            w_en_next  = w_pwm;
         end
         ST_BRAKE: begin
            w_in1_next = 1'b1;
            w_in2_next = 1'b1;
            w_en_next  = 1'b1;
         end
         ST_DEAD: begin
            w_busy_next  = 1'b1;
            w_ready_next = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_COAST;
         r_target   <= c_dir_coast;
         r_cur_dir  <= c_dir_coast;
         r_dead_cnt <= '0;
         r_cnt      <= '0;
         r_duty     <= '0;
         r_pending  <= '0;
         r_in1      <= 1'b0;
         r_in2      <= 1'b0;
         r_en       <= 1'b0;
         r_busy     <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_target   <= w_target_next;
         r_cur_dir  <= w_cur_dir_next;
         r_dead_cnt <= w_dead_next;
         r_cnt      <= w_cnt_next;
         r_duty     <= w_duty_next;
         r_pending  <= w_pending_next;
         r_in1      <= w_in1_next;
         r_in2      <= w_in2_next;
         r_en       <= w_en_next;
         r_busy     <= w_busy_next;
         r_ready    <= w_ready_next;
      end
   end

   assign in1       = r_in1;
   assign in2       = r_in2;
   assign en        = r_en;
   assign busy      = r_busy;
   assign cmd_ready = r_ready;
   assign cur_dir   = r_cur_dir;

endmodule

`default_nettype wire

// File: tb/tb_motor_dir_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_motor_dir_sequencer : directed scoreboard bench for motor_dir_sequencer|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_motor_dir_sequencer;

   localparam int PWM_BITS    = 4;
   localparam int DEAD_CYCLES = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_dir;
   logic [PWM_BITS-1:0] cmd_duty;
   logic                in1, in2, en, busy;
   logic [1:0]          cur_dir;

   always #5 clk = ~clk;

   motor_dir_sequencer #(
      .PWM_BITS    (PWM_BITS),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_duty  (cmd_duty),
      .in1       (in1),
      .in2       (in2),
      .en        (en),
      .busy      (busy),
      .cur_dir   (cur_dir)
   );

   logic [6:0] exp_q[$];
   string      tag_q[$];
   int         errors = 0;
   int         checks = 0;

   // Bench view of the spec: counter phase, applied duty, pending duty, direction.
   logic [3:0] tcnt, tduty, tpend;
   logic [1:0] tcur;

   // Packing: {in1, in2, en, busy, cmd_ready, cur_dir}
   function automatic logic [6:0] pins(input logic [1:0] dir, input logic pwm_on);
      case (dir)
         2'b01:   return {1'b1, 1'b0, pwm_on, 1'b0, 1'b1, 2'b01};
         2'b10:   return {1'b0, 1'b1, pwm_on, 1'b0, 1'b1, 2'b10};
         2'b11:   return {1'b1, 1'b1, 1'b1,   1'b0, 1'b1, 2'b11};
         default: return {1'b0, 1'b0, 1'b0,   1'b0, 1'b1, 2'b00};
      endcase
   endfunction

   function automatic logic [6:0] dead_v(input logic [1:0] cur);
      return {3'b000, 1'b1, 1'b0, cur};
   endfunction

   task automatic cyc(input string tag, input logic [6:0] e);
      logic [6:0] got, want;
      string      t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      tcnt = tcnt + 4'd1;
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      got  = {in1, in2, en, busy, cmd_ready, cur_dir};
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: in1,in2,en,busy,ready,cur_dir got %b expected %b", t, got, want);
      end
   endtask

   task automatic run_pwm(input string tag, input int n);
      logic [3:0] nc;
      for (int i = 0; i < n; i++) begin
         nc = tcnt + 4'd1;
         if (nc == 4'd0) begin
`ifdef SOFT_START_EN
            if (tduty < tpend) tduty = tduty + 4'd1;
            else if (tduty > tpend) tduty = tduty - 4'd1;
`else
            tduty = tpend;
`endif
         end
         cyc(tag, pins(tcur, nc < tduty));
      end
   endtask

   task automatic run_to(input string tag, input logic [3:0] c);
      for (int i = 0; i < 16 && tcnt != c; i++) begin
         run_pwm(tag, 1);
      end
   endtask

   task automatic accept_new(input string tag, input logic [1:0] dir, input logic [3:0] duty);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_duty  = duty;
      if (dir == 2'b01 || dir == 2'b10) tpend = duty;
      cyc(tag, dead_v(tcur));
      cmd_valid = 1'b0;
   endtask

   task automatic finish_dead(input string tag, input logic [1:0] dir);
      cyc(tag, dead_v(tcur));
      cyc(tag, dead_v(tcur));
      tcur = dir;
      if (dir == 2'b01 || dir == 2'b10) begin
`ifdef SOFT_START_EN
         tduty = 4'd0;
`else
         tduty = tpend;
`endif
         cyc(tag, pins(dir, 4'd0 < tduty));
         tcnt = 4'd0;
      end else begin
         cyc(tag, pins(dir, 1'b0));
      end
   endtask

   task automatic accept_same(input string tag, input logic [3:0] duty);
      cmd_valid = 1'b1;
      cmd_dir   = tcur;
      cmd_duty  = duty;
      tpend     = duty;
      run_pwm(tag, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic go_coast(input string tag);
      cmd_valid = 1'b1;
      cmd_dir   = 2'b00;
      tcur      = 2'b00;
      cyc(tag, pins(2'b00, 1'b0));
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_dir   = 2'b00;
      cmd_duty  = '0;
      tcnt      = 4'd0;
      tduty     = 4'd0;
      tpend     = 4'd0;
      tcur      = 2'b00;

      @(posedge clk);
      cyc("reset", pins(2'b00, 1'b0));
      tcnt = 4'd0;
      rst  = 1'b0;
      run_pwm("idle", 20);

      accept_new("coast_to_fwd", 2'b01, 4'd8);
      finish_dead("fwd_entry", 2'b01);
      run_pwm("fwd_d8", 31);
      run_to("fwd_d8", 4'd5);
      accept_same("fwd_upd_d4", 4'd4);
      run_pwm("fwd_d4", 40);

      // Reverse request, with a second command held valid across the dead time.
      accept_new("fwd_to_rev", 2'b10, 4'd6);
      cmd_valid = 1'b1;
      cmd_dir   = 2'b10;
      cmd_duty  = 4'd2;
      finish_dead("rev_entry_held", 2'b10);
      tpend = 4'd2;
      run_pwm("rev_held_accept", 1);
      cmd_valid = 1'b0;
      run_pwm("rev", 34);

      accept_new("rev_to_brake", 2'b11, 4'd0);
      finish_dead("brake_entry", 2'b11);
      run_pwm("brake", 3);
      go_coast("brake_to_coast");
      run_pwm("coast", 3);

      accept_new("coast_to_fwd15", 2'b01, 4'd15);
      finish_dead("fwd15_entry", 2'b01);
      run_pwm("fwd_d15", 20);
      accept_same("fwd_upd_d0", 4'd0);
      run_pwm("fwd_d0", 30);
      go_coast("fwd_to_coast");
      run_pwm("coast2", 2);

      // Reset in the middle of a dead-time run.
      accept_new("rev_then_reset", 2'b10, 4'd9);
      rst   = 1'b1;
      tcur  = 2'b00;
      cyc("rst_in_dead", pins(2'b00, 1'b0));
      rst   = 1'b0;
      tcnt  = 4'd0;
      tduty = 4'd0;
      tpend = 4'd0;
      run_pwm("post_rst", 6);

      // Soft-start profile (direct load when the ramp is not built in).
      accept_new("soft_start", 2'b01, 4'd3);
      finish_dead("soft_entry", 2'b01);
      run_pwm("soft_ramp", 79);
      run_to("soft_ramp", 4'd3);
      accept_same("soft_upd_d1", 4'd1);
      run_pwm("soft_down", 48);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
